// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding and default sizes for the Fibonacci term blocks
package fib_pkg;

  localparam int FIB_WIDTH = 4;
  localparam int FIB_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } fib_state_t;

endpackage

// File: rtl/fib_next_term.sv
// rtl/fib_next_term.sv - combinational next-term adder, WIDTH-bit sum plus carry out
module fib_next_term
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_term_sequencer.sv
// rtl/fib_term_sequencer.sv - Fibonacci term generator with valid/ready output and term count
// FIB_OVF_STOP_EN: stop the sequence and raise ovf when a term no longer fits in WIDTH bits.
module fib_term_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic [WIDTH-1:0] term_out,
  output logic             term_valid,
  input  logic             term_ready,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  fib_state_t       state;
  fib_state_t       state_nxt;
  logic [WIDTH-1:0] b;
  logic [CNT_W-1:0] n_lat;
  logic [WIDTH-1:0] sum;
  logic             hs;
  logic             last;
  logic             ovf_hit;
  logic             load;
  logic             advance;
  logic             set_ovf;

`ifdef FIB_OVF_STOP_EN
  logic sum_c;
  logic b_c;

  fib_next_term #(.WIDTH(WIDTH)) u_next (
    .a     (term_out),
    .b     (b),
    .sum   (sum),
    .carry (sum_c)
  );

  // b_c is the carry of the term about to move into a; checking it at the
  // handshake keeps an overflowed term from ever being presented.
  assign ovf_hit = b_c;
`else
  fib_next_term #(.WIDTH(WIDTH)) u_next (
    .a     (term_out),
    .b     (b),
    .sum   (sum),
    .carry ()
  );

  assign ovf_hit = 1'b0;
`endif

  assign hs   = (state == EMIT) && term_ready;
  assign last = (term_idx == (n_lat - 1'b1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    set_ovf   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (n_terms == '0) ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          advance = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end else if (ovf_hit) begin
            set_ovf   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so none depends on term_ready combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      term_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      term_valid <= (state_nxt == EMIT);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      term_out <= '0;
      b        <= '0;
      term_idx <= '0;
      n_lat    <= '0;
    end else if (load) begin
      term_out <= '0;
      b        <= {{(WIDTH-1){1'b0}}, 1'b1};
      term_idx <= '0;
      n_lat    <= n_terms;
    end else if (advance) begin
      term_out <= b;
      b        <= sum;
      term_idx <= term_idx + 1'b1;
    end
  end

`ifdef FIB_OVF_STOP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_c <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (load) begin
        b_c <= 1'b0;
      end else if (advance) begin
        b_c <= sum_c;
      end
      if (load) begin
        ovf <= 1'b0;
      end else if (set_ovf) begin
        ovf <= 1'b1;
      end
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fib_term_sequencer.sv
// tb/tb_fib_term_sequencer.sv - table-driven and randomized bench for fib_term_sequencer
module tb_fib_term_sequencer;
  import fib_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic [WIDTH-1:0] term_out;
  logic             term_valid;
  logic             term_ready;
  logic [CNT_W-1:0] term_idx;
  logic             busy;
  logic             done;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_q[$];
  bit exp_ovf;

  typedef struct {
    int n;
    int ready_pct;
    int stall_idx;
    bit poke;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fib_term_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_terms    (n_terms),
    .term_out   (term_out),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .term_idx   (term_idx),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: unbounded Fibonacci numbers, reduced modulo 2^WIDTH on output.
  task automatic build_model(input int n);
    longint f0 = 0;
    longint f1 = 1;
    longint t;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < n; k++) begin
`ifdef FIB_OVF_STOP_EN
      if (f0 >= (longint'(1) << WIDTH)) begin
        exp_ovf = 1'b1;
        break;
      end
`endif
      exp_q.push_back(int'(f0 % (longint'(1) << WIDTH)));
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
  endtask

  task automatic run_seq(input int n, input int ready_pct, input int stall_idx, input bit poke,
                         output int got, output bit ovf_seen);
    int   cyc = 1;
    int   last_hs = 0;
    int   stall_left = 3;
    bit   prev_stall = 1'b0;
    bit   seen_done = 1'b0;
    bit   rdy;
    logic [WIDTH-1:0] prev_term = '0;
    logic [CNT_W-1:0] prev_idx = '0;
    got = 0;
    build_model(n);
    @(negedge clk);
    start   = 1'b1;
    n_terms = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_latency", term_valid, (n > 0) ? 1 : 0);
    chk("ovf_cleared_on_start", ovf, 0);
    while (!seen_done && cyc < 400) begin
      if (prev_stall) begin
        chk("hold_term", term_out, prev_term);
        chk("hold_idx", term_idx, prev_idx);
      end
      if (done) begin
        seen_done = 1'b1;
        chk("done_timing", cyc, last_hs + 1);
        chk("no_valid_in_done", term_valid, 0);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        @(negedge clk);
        chk("start_in_done_ignored", busy, 0);
      end else begin
        if (stall_idx >= 0) begin
          if (term_valid && term_idx == CNT_W'(stall_idx) && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end else begin
            rdy = 1'b1;
          end
        end else begin
          rdy = ($urandom_range(99) < ready_pct);
        end
        term_ready = rdy;
        start      = poke;
        if (term_valid && rdy) begin
          chk("term_idx", term_idx, got);
          chk("term_val", term_out, (got < exp_q.size()) ? exp_q[got] : -1);
          got++;
          last_hs = cyc;
        end
        prev_stall = term_valid && !rdy;
        prev_term  = term_out;
        prev_idx   = term_idx;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("seq_done", seen_done, 1);
    chk("term_count_model", got, exp_q.size());
    chk("ovf_model", ovf, exp_ovf);
    ovf_seen = ovf;
  endtask

  initial begin
    int got;
    bit ovf_seen;
    int wait_cyc;

`ifdef FIB_OVF_STOP_EN
    vecs.push_back('{5,  100, -1, 1'b0, 5, 1'b0});
    vecs.push_back('{10, 100, -1, 1'b0, 8, 1'b1});
    vecs.push_back('{4,  100,  2, 1'b0, 4, 1'b0});
    vecs.push_back('{6,  100, -1, 1'b1, 6, 1'b0});
    vecs.push_back('{0,  100, -1, 1'b1, 0, 1'b0});
    vecs.push_back('{8,  60,  -1, 1'b0, 8, 1'b0});
    vecs.push_back('{9,  50,  -1, 1'b1, 8, 1'b1});
    vecs.push_back('{31, 100, -1, 1'b0, 8, 1'b1});
`else
    vecs.push_back('{5,  100, -1, 1'b0, 5,  1'b0});
    vecs.push_back('{10, 100, -1, 1'b0, 10, 1'b0});
    vecs.push_back('{4,  100,  2, 1'b0, 4,  1'b0});
    vecs.push_back('{6,  100, -1, 1'b1, 6,  1'b0});
    vecs.push_back('{0,  100, -1, 1'b1, 0,  1'b0});
    vecs.push_back('{8,  60,  -1, 1'b0, 8,  1'b0});
    vecs.push_back('{9,  50,  -1, 1'b1, 9,  1'b0});
    vecs.push_back('{31, 100, -1, 1'b0, 31, 1'b0});
`endif

    reset      = 1'b0;
    start      = 1'b0;
    n_terms    = '0;
    term_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_term_out", term_out, 0);
    chk("rst_term_valid", term_valid, 0);
    chk("rst_term_idx", term_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_seq(vecs[i].n, vecs[i].ready_pct, vecs[i].stall_idx, vecs[i].poke, got, ovf_seen);
      chk("tbl_count", got, vecs[i].exp_cnt);
      chk("tbl_ovf", ovf_seen, vecs[i].exp_ovf);
    end

    // Reset in the middle of a sequence drops it without a done pulse.
    @(negedge clk);
    start      = 1'b1;
    n_terms    = CNT_W'(8);
    term_ready = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_cyc = 0;
    while (term_idx != CNT_W'(3) && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("reached_idx3", term_idx, 3);
    #1 reset = 1'b0;
    #1;
    chk("midrst_valid", term_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", term_idx, 0);
    chk("midrst_term", term_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", done, 0);
    chk("midrst_idle", busy, 0);
    run_seq(2, 100, -1, 1'b0, got, ovf_seen);
    chk("after_rst_count", got, 2);

    for (int r = 0; r < 20; r++) begin
      run_seq(int'($urandom_range(31)), int'($urandom_range(100, 30)), -1,
              bit'($urandom_range(1)), got, ovf_seen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
